// File: rtl/ofdm_preamble_inserter.sv
// ofdm_preamble_inserter
//   Assembles one OFDM frame on a valid/ready I/Q stream. A frame is PRE_LEN
//   preamble samples fetched from a preamble ROM at addresses 0..PRE_LEN-1,
//   followed by frame_len payload samples forwarded from the upstream IFFT/CP
//   stage. A single output register slot decouples the stream from
//   downstream backpressure. No sample is dropped or duplicated.
//
//   Optional feature macro: OFDM_PREAMBLE_SHIFT_EN
//     defined   : adds input pre_shift[3:0], latched on an accepted start.
//                 Preamble samples (not payload) leave as an arithmetic right
//                 shift of the ROM word by pre_shift.
//     undefined : pre_shift is absent and preamble samples pass unmodified.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, frame_len     frame request pulse and payload length (0 = preamble only)
//   rom_addr, rom_en     preamble ROM read port (1-cycle read latency)
//   rom_i, rom_q         preamble ROM data, held by the ROM while rom_en=0
//   in_valid, in_ready   upstream payload handshake
//   in_i, in_q           upstream payload I/Q
//   out_valid, out_ready downstream handshake
//   out_i, out_q         output I/Q
//   out_first, out_last  first preamble sample / final sample of the frame
//   busy                 high from an accepted start until the last transfer
module ofdm_preamble_inserter #(
  parameter int PRE_LEN = 160,
  parameter int LEN_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
`ifdef OFDM_PREAMBLE_SHIFT_EN
  input  logic [3:0]       pre_shift,
`endif
  output logic [7:0]       rom_addr,
  output logic             rom_en,
  input  logic [15:0]      rom_i,
  input  logic [15:0]      rom_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_i,
  input  logic [15:0]      in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_i,
  output logic [15:0]      out_q,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_PAY  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_ADDR = 8'(PRE_LEN - 1);

  state_t           state_d, state_q;
  logic [7:0]       addr_d, addr_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic [LEN_W-1:0] pay_cnt_d, pay_cnt_q;
  logic             busy_d, busy_q;
  logic             out_valid_d, out_valid_q;
  logic             src_rom_d, src_rom_q;
  logic [15:0]      pay_i_d, pay_i_q;
  logic [15:0]      pay_q_d, pay_q_q;
  logic             first_d, first_q;
  logic             last_d, last_q;

  logic             slot_free_s;
  logic             rom_fire_s;
  logic             pay_fire_s;
  logic             last_rom_s;
  logic             last_pay_s;
  logic [15:0]      pre_i_s;
  logic [15:0]      pre_q_s;

  // The output slot can take a new sample when empty or being emptied now.
  assign slot_free_s = !out_valid_q || out_ready;
  assign rom_fire_s  = (state_q == S_PRE) && slot_free_s;
  assign pay_fire_s  = (state_q == S_PAY) && slot_free_s && in_valid;
  assign last_rom_s  = (addr_q == LAST_ADDR);
  assign last_pay_s  = (pay_cnt_q == (len_q - LEN_W'(1)));

`ifdef OFDM_PREAMBLE_SHIFT_EN
  logic [3:0] shift_d, shift_q;
  assign pre_i_s = $signed(rom_i) >>> shift_q;
  assign pre_q_s = $signed(rom_q) >>> shift_q;
`else
  assign pre_i_s = rom_i;
  assign pre_q_s = rom_q;
`endif

  // ROM data arrives one cycle after the read, so a preamble sample in the
  // slot is presented straight from the (held) ROM outputs rather than a copy.
  assign out_i     = src_rom_q ? pre_i_s : pay_i_q;
  assign out_q     = src_rom_q ? pre_q_s : pay_q_q;
  assign out_valid = out_valid_q;
  assign out_first = out_valid_q & first_q;
  assign out_last  = out_valid_q & last_q;
  assign busy      = busy_q;
  assign rom_en    = rom_fire_s;
  assign rom_addr  = addr_q;
  assign in_ready  = (state_q == S_PAY) && slot_free_s;

  // Next-state logic for the frame sequencer and the output slot.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    src_rom_d   = src_rom_q;
    pay_i_d     = pay_i_q;
    pay_q_d     = pay_q_q;
    first_d     = first_q;
    last_d      = last_q;
`ifdef OFDM_PREAMBLE_SHIFT_EN
    shift_d     = shift_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PRE;
          busy_d    = 1'b1;
          len_d     = frame_len;
          addr_d    = 8'd0;
          pay_cnt_d = {LEN_W{1'b0}};
`ifdef OFDM_PREAMBLE_SHIFT_EN
          shift_d   = pre_shift;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (rom_fire_s) begin
          if (last_rom_s) begin
            addr_d  = 8'd0;
            state_d = (len_q == {LEN_W{1'b0}}) ? S_DONE : S_PAY;
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      S_PAY: begin
        if (pay_fire_s) begin
          if (last_pay_s) begin
            state_d = S_DONE;
          end else begin
            pay_cnt_d = pay_cnt_q + LEN_W'(1);
          end
        end else begin
          state_d = S_PAY;
        end
      end
      S_DONE: begin
        // A start arriving with the last transfer is dropped: IDLE only
        // looks at start from the following cycle onward.
        if (out_valid_q && out_ready && last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (slot_free_s) begin
      if (rom_fire_s) begin
        out_valid_d = 1'b1;
        src_rom_d   = 1'b1;
        first_d     = (addr_q == 8'd0);
        last_d      = last_rom_s && (len_q == {LEN_W{1'b0}});
      end else if (pay_fire_s) begin
        out_valid_d = 1'b1;
        src_rom_d   = 1'b0;
        pay_i_d     = in_i;
        pay_q_d     = in_q;
        first_d     = 1'b0;
        last_d      = last_pay_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output-slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 8'd0;
      len_q       <= {LEN_W{1'b0}};
      pay_cnt_q   <= {LEN_W{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      src_rom_q   <= 1'b0;
      pay_i_q     <= 16'd0;
      pay_q_q     <= 16'd0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
`ifdef OFDM_PREAMBLE_SHIFT_EN
      shift_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      src_rom_q   <= src_rom_d;
      pay_i_q     <= pay_i_d;
      pay_q_q     <= pay_q_d;
      first_q     <= first_d;
      last_q      <= last_d;
`ifdef OFDM_PREAMBLE_SHIFT_EN
      shift_q     <= shift_d;
`endif
    end
  end

endmodule

// File: tb/tb_ofdm_preamble_inserter.sv
`timescale 1ns/1ps
module tb_ofdm_preamble_inserter;

  localparam int PRE_LEN = 160;
  localparam int LEN_W   = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] frame_len;
`ifdef OFDM_PREAMBLE_SHIFT_EN
  logic [3:0]       pre_shift;
  logic [3:0]       cur_shift;
`endif
  logic [7:0]       rom_addr;
  logic             rom_en;
  logic [15:0]      rom_i = 16'd0;
  logic [15:0]      rom_q = 16'd0;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_i;
  logic [15:0]      in_q;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_i;
  logic [15:0]      out_q;
  logic             out_first;
  logic             out_last;
  logic             busy;

  ofdm_preamble_inserter #(.PRE_LEN(PRE_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
`ifdef OFDM_PREAMBLE_SHIFT_EN
    .pre_shift (pre_shift),
`endif
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_i     (rom_i),
    .rom_q     (rom_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        first;
    logic        last;
  } samp_t;

  typedef struct {
    int          len;
    bit          rr;        // random out_ready
    bit          vr;        // random in_valid
    logic [15:0] base;      // first payload I value
    logic [3:0]  shift;
    int          poke;      // 0 none, 1 start mid-frame, 2 start on last transfer
    int          exp_xfers;
  } vec_t;

  logic [15:0] mem_i [256];
  logic [15:0] mem_q [256];
  samp_t       exp_q [$];
  vec_t        vecs  [8];

  int          n_vec = 0;
  int          n_err = 0;
  bit          rr = 1'b0;
  bit          vr = 1'b0;
  logic [15:0] pay_base = 16'd0;
  int          cur_len = 0;
  int          pay_idx = 0;
  int          beats = 0;
  int          xfers = 0;
  int          cyc = 0;
  int          first_cyc = -1;
  int          last_cyc = -1;
  bit          stall_prev = 1'b0;
  samp_t       held;
  samp_t       mon_e;
  samp_t       mon_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pre_model(input logic [15:0] v);
`ifdef OFDM_PREAMBLE_SHIFT_EN
    return 16'($signed(v) >>> cur_shift);
`else
    return v;
`endif
  endfunction

  // Preamble ROM: registered read, output held while not enabled.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_i <= mem_i[rom_addr];
      rom_q <= mem_q[rom_addr];
    end
  end

  // Upstream source and downstream sink drivers.
  initial begin
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_i      = 16'd0;
    in_q      = 16'hFFFF;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = vr ? 1'($urandom_range(0, 1)) : 1'b1;
      in_i      = pay_base + 16'(pay_idx);
      in_q      = ~in_i;
    end
  end

  // Scoreboard monitor: handshakes resolve at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (stall_prev)
        check("hold_while_stalled", {out_i, out_q, out_first, out_last}, held);
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("unexpected_sample", {out_i, out_q, out_first, out_last}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", {out_i, out_q, out_first, out_last}, mon_e);
        end
        if (out_first) first_cyc = cyc;
        if (out_last)  last_cyc  = cyc;
      end
      if (in_valid && in_ready) begin
        mon_p.i     = pay_base + 16'(pay_idx);
        mon_p.q     = ~mon_p.i;
        mon_p.first = 1'b0;
        mon_p.last  = (pay_idx == cur_len - 1);
        exp_q.push_back(mon_p);
        pay_idx++;
        beats++;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_i, out_q, out_first, out_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input vec_t v);
    samp_t p;
    bit    done_ok;
    rr        = v.rr;
    vr        = v.vr;
    pay_base  = v.base;
    cur_len   = v.len;
    pay_idx   = 0;
    beats     = 0;
    xfers     = 0;
    first_cyc = -1;
    last_cyc  = -1;
`ifdef OFDM_PREAMBLE_SHIFT_EN
    cur_shift = v.shift;
    pre_shift = v.shift;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < PRE_LEN; a++) begin
      p.i     = pre_model(mem_i[a]);
      p.q     = pre_model(mem_q[a]);
      p.first = (a == 0);
      p.last  = (a == PRE_LEN - 1) && (v.len == 0);
      exp_q.push_back(p);
    end
    frame_len = LEN_W'(v.len);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!v.rr) begin
      check("start_k1_rom_read", {rom_en, rom_addr, busy, out_valid}, {1'b1, 8'h00, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      check("start_k2_first_out", {out_valid, out_first, out_i},
            {1'b1, 1'b1, pre_model(mem_i[0])});
`ifdef OFDM_PREAMBLE_SHIFT_EN
      if (v.shift == 4'd2) check("shift_8000_by2", out_i, 16'hE000);
`endif
    end
    done_ok = 1'b0;
    for (int it = 0; it < 5000; it++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!busy) begin
        done_ok = 1'b1;
        break;
      end
      if (v.poke == 1 && it == 40) start = 1'b1;
      if (v.poke == 2 && out_valid && out_last && out_ready) start = 1'b1;
    end
    if (!done_ok) begin
      check("busy_timeout", 64'd0, 64'd1);
      apply_reset();
    end
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_frame", {busy, rom_en, out_valid, in_ready}, 4'b0000);
    check("transfer_count", xfers, v.exp_xfers);
    check("payload_beats", beats, v.len);
    check("scoreboard_empty", exp_q.size(), 0);
    if (!v.rr && !v.vr)
      check("no_gap_span", last_cyc - first_cyc, v.exp_xfers - 1);
    exp_q.delete();
  endtask

  task automatic mid_frame_reset();
    samp_t p;
    rr        = 1'b0;
    vr        = 1'b0;
    cur_len   = 3;
    pay_idx   = 0;
`ifdef OFDM_PREAMBLE_SHIFT_EN
    cur_shift = 4'd0;
    pre_shift = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < PRE_LEN; a++) begin
      p.i     = pre_model(mem_i[a]);
      p.q     = pre_model(mem_q[a]);
      p.first = (a == 0);
      p.last  = 1'b0;
      exp_q.push_back(p);
    end
    frame_len = LEN_W'(3);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_pre_outputs",
          {out_valid, out_i, out_q, out_first, out_last, busy, rom_en, rom_addr, in_ready},
          64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_idle", {busy, rom_en, out_valid}, 3'b000);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem_i[a] = 16'h1000 + 16'(a * 3);
      mem_q[a] = 16'hC000 - 16'(a);
    end
    mem_i[0] = 16'h8000;
    mem_i[1] = 16'h7FFF;
    mem_q[2] = 16'hF123;

    //          len  rr    vr    base      shift poke exp_xfers
    vecs[0] = '{0,   1'b0, 1'b0, 16'h0100, 4'd0, 0,   160};
    vecs[1] = '{4,   1'b0, 1'b0, 16'h0001, 4'd0, 0,   164};
    vecs[2] = '{4,   1'b0, 1'b0, 16'h0001, 4'd0, 2,   164};
    vecs[3] = '{13,  1'b1, 1'b1, 16'h7FF8, 4'd3, 1,   173};
    vecs[4] = '{4,   1'b0, 1'b0, 16'h8000, 4'd2, 0,   164};
    vecs[5] = '{1,   1'b1, 1'b0, 16'hFFFE, 4'd15, 0,  161};
    vecs[6] = '{25,  1'b1, 1'b1, 16'h4000, 4'd1, 1,   185};
    vecs[7] = '{0,   1'b1, 1'b1, 16'h0000, 4'd7, 0,   160};

    start     = 1'b0;
    frame_len = '0;
`ifdef OFDM_PREAMBLE_SHIFT_EN
    pre_shift = 4'd0;
    cur_shift = 4'd0;
`endif
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {out_valid, out_i, out_q, out_first, out_last, busy, rom_en, rom_addr, in_ready},
          64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_idle", {busy, rom_en, out_valid, in_ready}, 4'b0000);

    for (int v = 0; v < 8; v++) begin
      if (v == 4) mid_frame_reset();
      run_frame(vecs[v]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
